reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset controller for the ml505 top level. It synchronises and debounces the centre pushbutton and gates on PLL lock, then releases NUM_STAGES active-high reset outputs in order. Each stage is released only after the previous stage reports ready, for example memory `init_done` before the CPU and DVI are released. It replaces the fixed one-cycle reset pulse and shift-register stretch in the top level with configurable hold, debounce, stretch and per-stage handshakes.

## Interface
Parameters:
- SYNC_STAGES, 4: synchroniser depth for `btn`; minimum 2.
- DEBOUNCE_CYCLES, 16: consecutive high cycles of synchronised `btn` needed to accept a press.
- HOLD_CYCLES, 8: cycles all outputs stay asserted after lock is seen; minimum 1.
- NUM_STAGES, 3: number of reset outputs; minimum 1.
- STRETCH, 4: cycles `stage_ready[i]` must stay high before stage i+1 is released; minimum 1.
- TIMEOUT_CYCLES, 1024: ready-wait limit; used only with RESET_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (cpu_clk_g).
- rst_n  in  1  asynchronous active-low reset. Deassertion is synchronised externally.
- btn  in  1  asynchronous pushbutton, active-high.
- pll_lock  in  1  PLL locked, asynchronous.
- stage_ready  in  NUM_STAGES  bit i high when the domain behind `rst_out[i]` is ready.
- rst_out  out  NUM_STAGES  active-high resets, registered. Bit 0 is released first.
- busy  out  1  high whenever the state is not RUN.
- timeout_fault  out  1  sticky ready-timeout flag. Tied 0 without RESET_SEQ_TIMEOUT_EN.

## Operation
- While `rst_n` is low, asynchronously:
  - state = ASSERT
  - `rst_out` = all ones, `busy` = 1, `timeout_fault` = 0
  - all synchronisers and counters = 0
- `btn` synchroniser:
  - SYNC_STAGES flops produce `btn_s`.
  - The debounce counter increments while `btn_s`=1 and clears when `btn_s`=0.
  - A press is accepted on the cycle the counter reaches DEBOUNCE_CYCLES. The counter then saturates, so there is exactly one press per high period.
- `pll_lock` passes through 2 flops to give `lock_s`.
- Restart event: an accepted press, or `lock_s`=0. From any state, a restart event moves to ASSERT on the next edge; this takes priority over all other transitions.
- FSM:
  - ASSERT: all `rst_out`=1. If `lock_s`=1, go to HOLD and load the hold counter with HOLD_CYCLES-1.
  - HOLD: decrement each cycle. When the counter is 0, go to RELEASE with idx=0 and clear `rst_out[0]`.
  - RELEASE(idx):
    - The gap counter increments while `stage_ready[idx]`=1 and clears when it is 0.
    - When gap = STRETCH-1 and ready=1:
      - if idx<NUM_STAGES-1, clear `rst_out[idx+1]`, set idx+1 and clear gap;
      - otherwise go to RUN.
  - RUN: `busy`=0. Changes in `stage_ready` are ignored; only a restart event leaves RUN.
- Once cleared, a `rst_out` bit stays low until ASSERT. Entering ASSERT sets all bits in the same edge.
- Counter widths are $clog2 of the maximum value plus 1. Counters never wrap.

## Timing
- Edge 1 is the first rising `clk` edge after `rst_n` rises.
- With `pll_lock` steady high:
  - `lock_s`=1 at edge 2;
  - HOLD is entered at edge 3;
  - `rst_out[0]` falls at edge 3+HOLD_CYCLES.
- With `stage_ready[i]` already high, `rst_out[i+1]` falls exactly STRETCH edges after `rst_out[i]`. RUN (`busy` falls) follows STRETCH edges after the last release.
- A ready drop during RELEASE restarts the STRETCH count from 0.
- Lock loss reaches ASSERT 3 edges after `pll_lock` falls: 2 synchroniser edges plus 1 FSM edge.
- A press is accepted DEBOUNCE_CYCLES edges after `btn_s` rises. ASSERT follows on the next edge.
- A press and lock loss in the same cycle give a single entry to ASSERT.
- A press during HOLD or RELEASE restarts the sequence from ASSERT with a full HOLD.

## Configuration
- RESET_SEQ_TIMEOUT_EN defined:
  - A wait counter runs in RELEASE while `stage_ready[idx]`=0 and clears on a stage advance.
  - When the wait reaches TIMEOUT_CYCLES, `timeout_fault` sets and the FSM goes to ASSERT, then retries the full sequence.
  - `timeout_fault` clears only on `rst_n`.
- Undefined: RELEASE waits indefinitely and `timeout_fault` is constant 0.

## Test plan
- Power-up, default parameters, lock high, ready all 1, `btn` low → `rst_out` 3'b111 until edge 10; bit0 low at edge 11, bit1 at 15, bit2 at 19; `busy` low at 23.
- `stage_ready[0]` held 0 until edge 30, then 1 → `rst_out[1]` falls 4 edges after ready rises; `rst_out[2]` stays high until then.
- `btn` pulsed high for 10 cycles (less than 16) while in RUN → no change. High for 20 cycles → `rst_out`=3'b111 one edge after acceptance, then the full sequence replays; a single press only.
- `pll_lock` dropped for 1 cycle in RUN → `rst_out`=3'b111 3 edges later; resequences with a full 8-cycle HOLD.
- `rst_n` pulsed low mid-RELEASE (idx=1) → `rst_out`=3'b111 and `busy`=1 immediately, without waiting for a clock edge.
- With RESET_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=64, `stage_ready[1]` stuck 0 → `timeout_fault`=1 after 64 wait cycles, ASSERT, retry. Without the macro: stalls in RELEASE and `timeout_fault`=0.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: debounced, lock-gated staged reset release with per-stage ready handshakes; optional ready timeout under RESET_SEQ_TIMEOUT_EN
module reset_sequencer #(
  parameter int SYNC_STAGES     = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter int NUM_STAGES      = 3,
  parameter int STRETCH         = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn,
  input  logic                  pll_lock,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  busy,
  output logic                  timeout_fault
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STRETCH + 1);
  localparam int IW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_PRE    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STRETCH - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || STRETCH < 1) begin : g_bad_count
    $error("DEBOUNCE_CYCLES, HOLD_CYCLES and STRETCH must be at least 1");
  end
  if (NUM_STAGES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_stage
    $error("NUM_STAGES and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic [1:0]             lock_sync;
  logic [DW-1:0]          db_cnt;
  logic                   press;
  logic [HW-1:0]          hold_cnt;
  logic [GW-1:0]          gap;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          idx_n;
  logic                   btn_s;
  logic                   lock_s;
  logic                   restart;

  assign btn_s   = btn_sync[SYNC_STAGES-1];
  assign lock_s  = lock_sync[1];
  assign restart = press | ~lock_s;
  assign idx_n   = idx + 1'b1;

  // synchronise button and lock, debounce the button into a single-cycle press pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      btn_sync  <= '0;
      lock_sync <= '0;
      db_cnt    <= '0;
      press     <= 1'b0;
    end else begin
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn};
      lock_sync <= {lock_sync[0], pll_lock};
      db_cnt    <= !btn_s ? '0 : (db_cnt == DB_MAX ? db_cnt : db_cnt + 1'b1);
      press     <= btn_s && db_cnt == DB_PRE;
    end

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt;
`else
  assign timeout_fault = 1'b0;
`endif

  // sequencing FSM: restart has priority, then hold, then staged release gated by ready
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ASSERT;
      rst_out  <= '1;
      busy     <= 1'b1;
      hold_cnt <= '0;
      gap      <= '0;
      idx      <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_fault <= 1'b0;
`endif
    end else if (restart) begin
      state    <= ASSERT;
      rst_out  <= '1;
      busy     <= 1'b1;
      hold_cnt <= '0;
      gap      <= '0;
      idx      <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        ASSERT: if (lock_s) begin
          state    <= HOLD;
          hold_cnt <= HOLD_LOAD;
        end
        HOLD: if (hold_cnt == '0) begin
          state      <= RELEASE;
          rst_out[0] <= 1'b0;
          idx        <= '0;
          gap        <= '0;
        end else hold_cnt <= hold_cnt - 1'b1;
        RELEASE: if (!stage_ready[idx]) begin
          gap <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
          if (wait_cnt == TO_LAST) begin
            timeout_fault <= 1'b1;
            state         <= ASSERT;
            rst_out       <= '1;
            wait_cnt      <= '0;
            idx           <= '0;
          end else wait_cnt <= wait_cnt + 1'b1;
`endif
        end else if (gap == GAP_LAST) begin
          gap <= '0;
`ifdef RESET_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (idx == IDX_LAST) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            rst_out[idx_n] <= 1'b0;
            idx            <= idx_n;
          end
        end else gap <= gap + 1'b1;
        RUN: state <= RUN;
      endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: edge-timed expectations for the staged reset release, queued and checked against the DUT
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       pll_lock = 1'b1;
  logic [2:0] stage_ready = 3'b111;
  logic [2:0] rst_out;
  logic       busy;
  logic       timeout_fault;

  reset_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .pll_lock(pll_lock),
    .stage_ready(stage_ready), .rst_out(rst_out), .busy(busy),
    .timeout_fault(timeout_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         edge_n;
    logic [2:0] rst;
    logic       busy;
    logic       fault;
  } vec_t;

  vec_t sb[$];
  vec_t pu[10];
  int   compared = 0;
  int   mismatched = 0;
  int   ec = 0;

  task automatic run_to(input int e);
    while (ec < e) begin
      @(posedge clk);
      ec++;
    end
    #1;
  endtask

  task automatic push(input string n, input int e, input logic [2:0] r, input logic b, input logic f);
    vec_t v;
    v = '{n, e, r, b, f};
    sb.push_back(v);
  endtask

  task automatic check_pop();
    vec_t v;
    v = sb.pop_front();
    compared++;
    if (rst_out !== v.rst || busy !== v.busy || timeout_fault !== v.fault) begin
      mismatched++;
      $display("FAIL %s (edge %0d): got rst_out=%b busy=%b timeout_fault=%b, expected rst_out=%b busy=%b timeout_fault=%b",
               v.name, ec, rst_out, busy, timeout_fault, v.rst, v.busy, v.fault);
    end
  endtask

  task automatic expect_at(input string n, input int e, input logic [2:0] r, input logic b, input logic f);
    push(n, e, r, b, f);
    run_to(e);
    check_pop();
  endtask

  task automatic start(input logic [2:0] rdy);
    rst_n = 1'b0;
    stage_ready = rdy;
    btn = 1'b0;
    pll_lock = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    push("reset_state", 0, 3'b111, 1'b1, 1'b0);
    check_pop();
    @(negedge clk);
    rst_n = 1'b1;
    ec = 0;
  endtask

  int b, a, f;

  initial begin
    pu = '{
      '{"pu_e2",  2,  3'b111, 1'b1, 1'b0},
      '{"pu_e10", 10, 3'b111, 1'b1, 1'b0},
      '{"pu_e11", 11, 3'b110, 1'b1, 1'b0},
      '{"pu_e14", 14, 3'b110, 1'b1, 1'b0},
      '{"pu_e15", 15, 3'b100, 1'b1, 1'b0},
      '{"pu_e18", 18, 3'b100, 1'b1, 1'b0},
      '{"pu_e19", 19, 3'b000, 1'b1, 1'b0},
      '{"pu_e22", 22, 3'b000, 1'b1, 1'b0},
      '{"pu_e23", 23, 3'b000, 1'b0, 1'b0},
      '{"pu_e30", 30, 3'b000, 1'b0, 1'b0}
    };
    start(3'b111);
    foreach (pu[i]) sb.push_back(pu[i]);
    while (sb.size() > 0) begin
      run_to(sb[0].edge_n);
      check_pop();
    end

    start(3'b110);
    expect_at("stall_e11", 11, 3'b110, 1'b1, 1'b0);
    expect_at("stall_e30", 30, 3'b110, 1'b1, 1'b0);
    stage_ready = 3'b111;
    expect_at("rdy_e33", 33, 3'b110, 1'b1, 1'b0);
    expect_at("rdy_e34", 34, 3'b100, 1'b1, 1'b0);
    expect_at("rdy_e37", 37, 3'b100, 1'b1, 1'b0);
    expect_at("rdy_e38", 38, 3'b000, 1'b1, 1'b0);
    expect_at("rdy_e41", 41, 3'b000, 1'b1, 1'b0);
    expect_at("rdy_e42", 42, 3'b000, 1'b0, 1'b0);

    b = ec;
    btn = 1'b1;
    run_to(b + 10);
    btn = 1'b0;
    expect_at("short_btn", b + 40, 3'b000, 1'b0, 1'b0);
    b = ec;
    btn = 1'b1;
    expect_at("press_accept", b + 20, 3'b000, 1'b0, 1'b0);
    btn = 1'b0;
    expect_at("press_assert", b + 21, 3'b111, 1'b1, 1'b0);
    a = b + 21;
    expect_at("press_hold", a + 8,  3'b111, 1'b1, 1'b0);
    expect_at("press_rel0", a + 9,  3'b110, 1'b1, 1'b0);
    expect_at("press_rel1", a + 13, 3'b100, 1'b1, 1'b0);
    expect_at("press_rel2", a + 17, 3'b000, 1'b1, 1'b0);
    expect_at("press_run",  a + 21, 3'b000, 1'b0, 1'b0);
    expect_at("press_once", a + 60, 3'b000, 1'b0, 1'b0);

    f = ec;
    pll_lock = 1'b0;
    run_to(f + 1);
    pll_lock = 1'b1;
    expect_at("lock_e2",     f + 2,  3'b000, 1'b0, 1'b0);
    expect_at("lock_assert", f + 3,  3'b111, 1'b1, 1'b0);
    expect_at("lock_hold",   f + 11, 3'b111, 1'b1, 1'b0);
    expect_at("lock_rel0",   f + 12, 3'b110, 1'b1, 1'b0);
    expect_at("lock_rel1",   f + 16, 3'b100, 1'b1, 1'b0);

    run_to(f + 17);
    #2;
    rst_n = 1'b0;
    #1;
    push("async_rst", ec, 3'b111, 1'b1, 1'b0);
    check_pop();

    start(3'b111);
    run_to(12);
    stage_ready = 3'b110;
    run_to(13);
    stage_ready = 3'b111;
    expect_at("drop_e16", 16, 3'b110, 1'b1, 1'b0);
    expect_at("drop_e17", 17, 3'b100, 1'b1, 1'b0);

    start(3'b101);
    expect_at("to_e15", 15, 3'b100, 1'b1, 1'b0);
`ifdef RESET_SEQ_TIMEOUT_EN
    expect_at("to_e78",    78, 3'b100, 1'b1, 1'b0);
    expect_at("to_fault",  79, 3'b111, 1'b1, 1'b1);
    expect_at("to_hold",   87, 3'b111, 1'b1, 1'b1);
    expect_at("to_retry",  88, 3'b110, 1'b1, 1'b1);
`else
    expect_at("to_stall",  200, 3'b100, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
